// File: rtl/tt_pkg.sv
// Shared definitions for the marble launcher: FSM state encoding,
// count width and a saturating increment helper.
package tt_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RELEASE = 3'd1,
      S_FLIGHT  = 3'd2,
      S_DONE    = 3'd3,
      S_ERROR   = 3'd4
   } state_e;

   // Plain constants for the FSM register, so state_q can stay a bare logic vector
   localparam logic [2:0] ST_IDLE    = S_IDLE;
   localparam logic [2:0] ST_RELEASE = S_RELEASE;
   localparam logic [2:0] ST_FLIGHT  = S_FLIGHT;
   localparam logic [2:0] ST_DONE    = S_DONE;
   localparam logic [2:0] ST_ERROR   = S_ERROR;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/tt_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
// The detector is held off for the first three cycles after reset, so a pin
// that is already high when reset is released looks like a steady level and
// never like a fresh edge.
module tt_edge_sync (
   input  logic clk,
   input  logic rst,
   input  logic async_i,
   output logic rise_o
);

   logic       meta_q;
   logic       sync_q;
   logic       prev_q;
   logic [1:0] arm_q;

   // Synchroniser chain, previous-level flop and warm-up counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
         arm_q  <= 2'd0;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
         if (arm_q != 2'd3) begin
            arm_q <= arm_q + 2'd1;
         end
      end
   end

   assign rise_o = (arm_q == 2'd3) & sync_q & ~prev_q;

endmodule

// File: rtl/ball_launcher.sv
// Marble launcher controller: releases blue (left) or red (right) marbles
// into the board, watches the bottom triggers and the interceptor, and
// chains further releases until a reservoir runs dry, the marble is
// intercepted, or it stays in flight too long.
module ball_launcher
   import tt_pkg::*;
#(
   parameter int BLUE_INIT = 8,
   parameter int RED_INIT  = 8,
   parameter int PULSE_LEN = 2,
   parameter int TIMEOUT   = 64
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             start_sel,
   input  logic             reload,
   input  logic             abort,
   input  logic             trig_left,
   input  logic             trig_right,
   input  logic             intercepted,
   output logic             drop_left,
   output logic             drop_right,
   output logic [CNT_W-1:0] blue_cnt,
   output logic [CNT_W-1:0] red_cnt,
   output logic [CNT_W-1:0] dropped,
   output logic [2:0]       state,
   output logic             busy,
   output logic             done,
   output logic             error
);

   localparam int PW = $clog2(PULSE_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [PW-1:0]    PULSE_LAST  = PW'(PULSE_LEN - 1);
   localparam logic [TW-1:0]    FLIGHT_LAST = TW'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] BLUE_RST    = CNT_W'(BLUE_INIT);
   localparam logic [CNT_W-1:0] RED_RST     = CNT_W'(RED_INIT);

   logic [2:0]       state_q,      state_d;
   logic             drop_left_q,  drop_left_d;
   logic             drop_right_q, drop_right_d;
   logic [CNT_W-1:0] blue_q,       blue_d;
   logic [CNT_W-1:0] red_q,        red_d;
   logic [CNT_W-1:0] dropped_q,    dropped_d;
   logic [PW-1:0]    pulse_q,      pulse_d;
   logic [TW-1:0]    flight_q,     flight_d;

   logic left_rise;
   logic right_rise;
   logic icpt_rise;
   logic rel_go;
   logic rel_red;
   logic reload_ok;

   tt_edge_sync u_sync_left (
      .clk     (clk),
      .rst     (rst),
      .async_i (trig_left),
      .rise_o  (left_rise)
   );

   tt_edge_sync u_sync_right (
      .clk     (clk),
      .rst     (rst),
      .async_i (trig_right),
      .rise_o  (right_rise)
   );

   tt_edge_sync u_sync_icpt (
      .clk     (clk),
      .rst     (rst),
      .async_i (intercepted),
      .rise_o  (icpt_rise)
   );

   assign reload_ok = (state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERROR);

   // Next-state logic: normal FSM flow first, then reload, then abort which wins over everything
   always_comb begin
      state_d      = state_q;
      drop_left_d  = drop_left_q;
      drop_right_d = drop_right_q;
      blue_d       = blue_q;
      red_d        = red_q;
      dropped_d    = dropped_q;
      pulse_d      = pulse_q;
      flight_d     = flight_q;
      rel_go       = 1'b0;
      rel_red      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (start_sel ? (red_q != '0) : (blue_q != '0)) begin
                  rel_go  = 1'b1;
                  rel_red = start_sel;
               end else begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_RELEASE: begin
            if (pulse_q >= PULSE_LAST) begin
               state_d      = ST_FLIGHT;
               drop_left_d  = 1'b0;
               drop_right_d = 1'b0;
               flight_d     = '0;
            end else begin
               pulse_d = pulse_q + PW'(1);
            end
         end
         ST_FLIGHT: begin
            if (icpt_rise) begin
               state_d = ST_DONE;
            end else if (left_rise) begin
               if (blue_q != '0) begin
                  rel_go  = 1'b1;
                  rel_red = 1'b0;
               end else begin
                  state_d = ST_DONE;
               end
            end else if (right_rise) begin
               if (red_q != '0) begin
                  rel_go  = 1'b1;
                  rel_red = 1'b1;
               end else begin
                  state_d = ST_DONE;
               end
            end else if (flight_q >= FLIGHT_LAST) begin
               state_d = ST_ERROR;
            end else begin
               flight_d = flight_q + TW'(1);
            end
         end
         ST_DONE, ST_ERROR: begin
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (rel_go) begin
         state_d      = ST_RELEASE;
         pulse_d      = '0;
         drop_left_d  = ~rel_red;
         drop_right_d = rel_red;
         dropped_d    = sat_inc(dropped_q);
         if (rel_red) begin
            red_d = red_q - CNT_W'(1);
         end else begin
            blue_d = blue_q - CNT_W'(1);
         end
      end

      if (reload && reload_ok) begin
         state_d      = ST_IDLE;
         drop_left_d  = 1'b0;
         drop_right_d = 1'b0;
         blue_d       = BLUE_RST;
         red_d        = RED_RST;
         dropped_d    = '0;
         pulse_d      = '0;
         flight_d     = '0;
      end

      if (abort) begin
         state_d      = ST_IDLE;
         drop_left_d  = 1'b0;
         drop_right_d = 1'b0;
         blue_d       = blue_q;
         red_d        = red_q;
         dropped_d    = dropped_q;
         pulse_d      = '0;
         flight_d     = '0;
      end
   end

   // State, drop pulses, marble counts and the pulse/flight counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         drop_left_q  <= 1'b0;
         drop_right_q <= 1'b0;
         blue_q       <= BLUE_RST;
         red_q        <= RED_RST;
         dropped_q    <= '0;
         pulse_q      <= '0;
         flight_q     <= '0;
      end else begin
         state_q      <= state_d;
         drop_left_q  <= drop_left_d;
         drop_right_q <= drop_right_d;
         blue_q       <= blue_d;
         red_q        <= red_d;
         dropped_q    <= dropped_d;
         pulse_q      <= pulse_d;
         flight_q     <= flight_d;
      end
   end

   assign state      = state_q;
   assign drop_left  = drop_left_q;
   assign drop_right = drop_right_q;
   assign blue_cnt   = blue_q;
   assign red_cnt    = red_q;
   assign dropped    = dropped_q;
   assign busy       = (state_q == ST_RELEASE) || (state_q == ST_FLIGHT);
   assign done       = (state_q == ST_DONE);
   assign error      = (state_q == ST_ERROR);

endmodule

// File: tb/tb_ball_launcher.sv
// Directed testbench for ball_launcher with default parameters.
// Each scenario task drives the pins and compares a snapshot of all outputs
// against hand-computed values.
module tb_ball_launcher;

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REL  = 3'd1;
   localparam logic [2:0] S_FLT  = 3'd2;
   localparam logic [2:0] S_DONE = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       startSel;
   logic       reload;
   logic       abort;
   logic       trigLeft;
   logic       trigRight;
   logic       intercepted;
   logic       dropLeft;
   logic       dropRight;
   logic [7:0] blueCnt;
   logic [7:0] redCnt;
   logic [7:0] droppedCnt;
   logic [2:0] stateOut;
   logic       busy;
   logic       done;
   logic       error;

   logic [31:0] snap;
   logic [31:0] exp;
   int          checkCount = 0;
   int          errorCount = 0;

   ball_launcher dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .start_sel   (startSel),
      .reload      (reload),
      .abort       (abort),
      .trig_left   (trigLeft),
      .trig_right  (trigRight),
      .intercepted (intercepted),
      .drop_left   (dropLeft),
      .drop_right  (dropRight),
      .blue_cnt    (blueCnt),
      .red_cnt     (redCnt),
      .dropped     (droppedCnt),
      .state       (stateOut),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   always #5 clk = ~clk;

   assign snap = {stateOut, busy, done, error, dropLeft, dropRight, blueCnt, redCnt, droppedCnt};

   // Advance n rising edges and settle 1 time unit past the last one
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected output snapshot; busy/done/error follow from the state
   function automatic logic [31:0] mk(input logic [2:0] st, input logic dl, input logic dr,
                                      input logic [7:0] b, input logic [7:0] r, input logic [7:0] d);
      logic bz, dn, er;
      bz = (st == S_REL) || (st == S_FLT);
      dn = (st == S_DONE);
      er = (st == S_ERR);
      return {st, bz, dn, er, dl, dr, b, r, d};
   endfunction

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; startSel = 1'b0; reload = 1'b0; abort = 1'b0;
      trigLeft = 1'b0; trigRight = 1'b0; intercepted = 1'b0;
      step(2);
      exp = mk(S_IDLE, 0, 0, 8'd8, 8'd8, 8'd0);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL reset_state: got %h expected %h", snap, exp); end
      rst = 1'b0;
      step(4);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL post_reset_idle: got %h expected %h", snap, exp); end
   endtask

   task automatic test_release_blue();
      start = 1'b1; startSel = 1'b0;
      step(1);
      start = 1'b0;
      exp = mk(S_REL, 1, 0, 8'd7, 8'd8, 8'd1);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL rel_blue_entry: got %h expected %h", snap, exp); end
      step(1);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL rel_blue_hold: got %h expected %h", snap, exp); end
      step(1);
      exp = mk(S_FLT, 0, 0, 8'd7, 8'd8, 8'd1);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL rel_blue_flight: got %h expected %h", snap, exp); end
      start = 1'b1;
      step(1);
      start = 1'b0;
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL start_ignored_flight: got %h expected %h", snap, exp); end
      reload = 1'b1;
      step(1);
      reload = 1'b0;
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL reload_ignored_flight: got %h expected %h", snap, exp); end
   endtask

   task automatic test_trig_right();
      trigRight = 1'b1;
      step(2);
      exp = mk(S_FLT, 0, 0, 8'd7, 8'd8, 8'd1);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL trig_right_latency: got %h expected %h", snap, exp); end
      step(1);
      exp = mk(S_REL, 0, 1, 8'd7, 8'd7, 8'd2);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL trig_right_release: got %h expected %h", snap, exp); end
      trigRight = 1'b0;
      step(1);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL drop_right_hold: got %h expected %h", snap, exp); end
      step(1);
      exp = mk(S_FLT, 0, 0, 8'd7, 8'd7, 8'd2);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL back_to_flight: got %h expected %h", snap, exp); end
   endtask

   task automatic test_intercept_priority();
      intercepted = 1'b1; trigLeft = 1'b1;
      step(3);
      exp = mk(S_DONE, 0, 0, 8'd7, 8'd7, 8'd2);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL intercept_wins: got %h expected %h", snap, exp); end
      intercepted = 1'b0; trigLeft = 1'b0;
      step(3);
      trigLeft = 1'b1;
      step(4);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL edge_discarded_done: got %h expected %h", snap, exp); end
      trigLeft = 1'b0; start = 1'b1; startSel = 1'b0;
      step(2);
      start = 1'b0;
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL start_ignored_done: got %h expected %h", snap, exp); end
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      exp = mk(S_IDLE, 0, 0, 8'd7, 8'd7, 8'd2);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL abort_to_idle: got %h expected %h", snap, exp); end
   endtask

   task automatic test_timeout();
      start = 1'b1; startSel = 1'b0;
      step(1);
      start = 1'b0;
      step(2);
      exp = mk(S_FLT, 0, 0, 8'd6, 8'd7, 8'd3);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL timeout_flight_entry: got %h expected %h", snap, exp); end
      step(63);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL timeout_minus_one: got %h expected %h", snap, exp); end
      step(1);
      exp = mk(S_ERR, 0, 0, 8'd6, 8'd7, 8'd3);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL timeout_error: got %h expected %h", snap, exp); end
      start = 1'b1;
      step(2);
      start = 1'b0;
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL error_ignores_start: got %h expected %h", snap, exp); end
      abort = 1'b1; reload = 1'b1;
      step(1);
      abort = 1'b0; reload = 1'b0;
      exp = mk(S_IDLE, 0, 0, 8'd6, 8'd7, 8'd3);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL abort_beats_reload: got %h expected %h", snap, exp); end
   endtask

   task automatic test_abort_release();
      start = 1'b1; startSel = 1'b1;
      step(1);
      start = 1'b0;
      exp = mk(S_REL, 0, 1, 8'd6, 8'd6, 8'd4);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL abort_pre_release: got %h expected %h", snap, exp); end
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      exp = mk(S_IDLE, 0, 0, 8'd6, 8'd6, 8'd4);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL abort_in_release: got %h expected %h", snap, exp); end
   endtask

   task automatic test_drain_blue();
      start = 1'b1; startSel = 1'b0;
      step(1);
      start = 1'b0;
      exp = mk(S_REL, 1, 0, 8'd5, 8'd6, 8'd5);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL drain_first: got %h expected %h", snap, exp); end
      for (int k = 1; k <= 5; k++) begin
         step(2);
         trigLeft = 1'b1;
         step(3);
         trigLeft = 1'b0;
         exp = mk(S_REL, 1, 0, 8'(5 - k), 8'd6, 8'(5 + k));
         checkCount++;
         if (snap !== exp) begin errorCount++; $display("[TB] FAIL drain_step%0d: got %h expected %h", k, snap, exp); end
      end
      step(2);
      exp = mk(S_FLT, 0, 0, 8'd0, 8'd6, 8'd10);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL drain_empty_flight: got %h expected %h", snap, exp); end
      trigLeft = 1'b1;
      step(3);
      trigLeft = 1'b0;
      exp = mk(S_DONE, 0, 0, 8'd0, 8'd6, 8'd10);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL empty_trig_done: got %h expected %h", snap, exp); end
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      start = 1'b1; startSel = 1'b0;
      step(1);
      start = 1'b0;
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL empty_start_done: got %h expected %h", snap, exp); end
      reload = 1'b1;
      step(1);
      reload = 1'b0;
      exp = mk(S_IDLE, 0, 0, 8'd8, 8'd8, 8'd0);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL reload_restore: got %h expected %h", snap, exp); end
   endtask

   task automatic test_stale_level();
      trigLeft = 1'b1; rst = 1'b1;
      step(2);
      rst = 1'b0;
      step(5);
      start = 1'b1; startSel = 1'b0;
      step(1);
      start = 1'b0;
      step(2);
      exp = mk(S_FLT, 0, 0, 8'd7, 8'd8, 8'd1);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL stale_flight: got %h expected %h", snap, exp); end
      step(10);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL stale_no_event: got %h expected %h", snap, exp); end
      rst = 1'b1;
      #1;
      exp = mk(S_IDLE, 0, 0, 8'd8, 8'd8, 8'd0);
      checkCount++;
      if (snap !== exp) begin errorCount++; $display("[TB] FAIL rst_mid_flight: got %h expected %h", snap, exp); end
      rst = 1'b0; trigLeft = 1'b0;
      step(2);
   endtask

   initial begin
      test_reset();
      test_release_blue();
      test_trig_right();
      test_intercept_priority();
      test_timeout();
      test_abort_release();
      test_drain_blue();
      test_stale_level();
      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
